regfile_dbg_ctrl: RTL

//  Sits between the single-cycle core and the 32-entry register file. Owns the register file write

---
 rtl/regfile_dbg_ctrl_pkg.sv | 27 ++
 rtl/regfile_dbg_ctrl_if.sv | 65 ++++++
 rtl/regfile_dbg_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/regfile_dbg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_ctrl_pkg
//  Description : Shared types and defaults for the register-file debug controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_ctrl_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_DUMP  = 2'b10,
        OP_RSVD  = 2'b11
    } dbg_op_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HALTED   = 2'd1,
        ST_DUMP     = 2'd2,
        ST_RSP_WAIT = 2'd3
    } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_dbg_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_dbg_ctrl_if
//  Description : Core, register-file and debug-host signals of the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_dbg_ctrl_if
    import regfile_ctrl_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS
);
    localparam int AW = $clog2(NREGS);

    logic            core_we;
    logic [AW-1:0]   core_rd;
    logic [XLEN-1:0] core_wdata;
    logic [AW-1:0]   core_rs1;
    logic            core_stall;

    logic            rf_we;
    logic [AW-1:0]   rf_rsW;
    logic [XLEN-1:0] rf_wdata;
    logic [AW-1:0]   rf_rs1;
    logic [XLEN-1:0] rf_rdata1;

    logic            dbg_halt_req;
    logic            dbg_halted;
    logic            dbg_cmd_valid;
    logic            dbg_cmd_ready;
    dbg_op_e         dbg_cmd_op;
    logic [AW-1:0]   dbg_cmd_addr;
    logic [XLEN-1:0] dbg_cmd_wdata;
    logic            dbg_rsp_valid;
    logic            dbg_rsp_ready;
    logic [AW-1:0]   dbg_rsp_addr;
    logic [XLEN-1:0] dbg_rsp_data;
    logic            dbg_rsp_last;

    // Controller side
    modport slave (
        input  core_we, core_rd, core_wdata, core_rs1,
        output core_stall,
        output rf_we, rf_rsW, rf_wdata, rf_rs1,
        input  rf_rdata1,
        input  dbg_halt_req, dbg_cmd_valid, dbg_cmd_op, dbg_cmd_addr, dbg_cmd_wdata,
        input  dbg_rsp_ready,
        output dbg_halted, dbg_cmd_ready,
        output dbg_rsp_valid, dbg_rsp_addr, dbg_rsp_data, dbg_rsp_last
    );

    // Core / register file / debug host side
    modport master (
        output core_we, core_rd, core_wdata, core_rs1,
        input  core_stall,
        input  rf_we, rf_rsW, rf_wdata, rf_rs1,
        output rf_rdata1,
        output dbg_halt_req, dbg_cmd_valid, dbg_cmd_op, dbg_cmd_addr, dbg_cmd_wdata,
        output dbg_rsp_ready,
        input  dbg_halted, dbg_cmd_ready,
        input  dbg_rsp_valid, dbg_rsp_addr, dbg_rsp_data, dbg_rsp_last
    );

endinterface
`default_nettype wire

// File: rtl/regfile_dbg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_dbg_ctrl
//  Description : Halts the core and serves debug read/write/dump of the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_dbg_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS
)
(
    input  wire logic         clk,
    input  wire logic         rst,
    regfile_dbg_ctrl_if.slave bus
);

    localparam int          AW         = $clog2(NREGS);
    localparam logic [AW:0] C_LAST_IDX = (AW+1)'(NREGS - 1);
    localparam logic [AW:0] C_ONE      = (AW+1)'(1);

    ctrl_state_e     r_state;
    ctrl_state_e     w_state_nxt;
    logic [AW:0]     r_cnt;
    logic [AW:0]     w_cnt_nxt;
    logic            r_rsp_valid;
    logic            w_rsp_valid_nxt;
    logic [AW-1:0]   r_rsp_addr;
    logic [AW-1:0]   w_rsp_addr_nxt;
    logic [XLEN-1:0] r_rsp_data;
    logic [XLEN-1:0] w_rsp_data_nxt;
    logic            r_rsp_last;
    logic            w_rsp_last_nxt;

    logic            w_rf_we;
    logic [AW-1:0]   w_rf_rsW;
    logic [XLEN-1:0] w_rf_wdata;
    logic [AW-1:0]   w_rf_rs1;
    logic [XLEN-1:0] w_rd_val;

    // Port steering: core owns the ports in RUN, debug owns them otherwise
    always_comb begin
        w_rf_we    = bus.core_we;
        w_rf_rsW   = bus.core_rd;
        w_rf_wdata = bus.core_wdata;
        w_rf_rs1   = bus.core_rs1;
        if (r_state != ST_RUN) begin
            w_rf_we    = 1'b0;
            w_rf_rsW   = bus.dbg_cmd_addr;
            w_rf_wdata = bus.dbg_cmd_wdata;
            w_rf_rs1   = (r_state == ST_DUMP) ? r_cnt[AW-1:0] : bus.dbg_cmd_addr;
            if ((r_state == ST_HALTED) && bus.dbg_cmd_valid &&
                (bus.dbg_cmd_op == OP_WRITE) && (bus.dbg_cmd_addr != '0)) begin
                w_rf_we = 1'b1;
            end
        end
    end

    // x0 always reads back as zero to the host
    assign w_rd_val = (w_rf_rs1 == '0) ? '0 : bus.rf_rdata1;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_addr_nxt  = r_rsp_addr;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_last_nxt  = r_rsp_last;
        case (r_state)
            ST_RUN: begin
                if (bus.dbg_halt_req) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (bus.dbg_cmd_valid) begin
                    case (bus.dbg_cmd_op)
                        OP_READ: begin
                            w_rsp_valid_nxt = 1'b1;
                            w_rsp_addr_nxt  = bus.dbg_cmd_addr;
                            w_rsp_data_nxt  = w_rd_val;
                            w_rsp_last_nxt  = 1'b1;
                            w_state_nxt     = ST_RSP_WAIT;
                        end
                        OP_DUMP: begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_DUMP;
                        end
                        default: ;
                    endcase
                end else if (!bus.dbg_halt_req) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DUMP: begin
                // A beat loads only into an empty or draining response slot
                if (!r_rsp_valid || bus.dbg_rsp_ready) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_addr_nxt  = r_cnt[AW-1:0];
                    w_rsp_data_nxt  = w_rd_val;
                    w_rsp_last_nxt  = (r_cnt == C_LAST_IDX);
                    w_cnt_nxt       = r_cnt + C_ONE;
                    if (r_cnt == C_LAST_IDX) begin
                        w_state_nxt = ST_RSP_WAIT;
                    end
                end
            end
            ST_RSP_WAIT: begin
                if (r_rsp_valid && bus.dbg_rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = bus.dbg_halt_req ? ST_HALTED : ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
            r_rsp_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_addr  <= w_rsp_addr_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_last  <= w_rsp_last_nxt;
        end
    end

    assign bus.rf_we         = w_rf_we;
    assign bus.rf_rsW        = w_rf_rsW;
    assign bus.rf_wdata      = w_rf_wdata;
    assign bus.rf_rs1        = w_rf_rs1;
    assign bus.core_stall    = (r_state != ST_RUN);
    assign bus.dbg_halted    = (r_state != ST_RUN);
    assign bus.dbg_cmd_ready = (r_state == ST_HALTED);
    assign bus.dbg_rsp_valid = r_rsp_valid;
    assign bus.dbg_rsp_addr  = r_rsp_addr;
    assign bus.dbg_rsp_data  = r_rsp_data;
    assign bus.dbg_rsp_last  = r_rsp_last;

endmodule
`default_nettype wire
